// File: rtl/bitwise_ops_defs.sv
// Shared op codes and FSM state encoding for the bitwise unit arbiter.
package bitwise_ops_defs;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_NAND = 2'b01;
   localparam logic [1:0] OP_OR   = 2'b10;
   localparam logic [1:0] OP_NOR  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/and16_gate.sv
// 16-bit bitwise AND gate, the shared core of the datapath.
module and16_gate (
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   output logic [15:0] o_y
);
   assign o_y = i_a & i_b;
endmodule

// File: rtl/bitwise_op_unit.sv
// Combinational datapath: every op is built from one AND16 core with
// optional operand inversion (OR, NOR) and optional result inversion (NAND, OR).
module bitwise_op_unit
   import bitwise_ops_defs::*;
(
   input  logic [1:0]  i_op,
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   output logic [15:0] o_out
);
   logic        w_in_inv;
   logic        w_out_inv;
   logic [15:0] w_a_n;
   logic [15:0] w_b_n;
   logic [15:0] w_core_a;
   logic [15:0] w_core_b;
   logic [15:0] w_core_y;
   logic [15:0] w_core_y_n;

   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      w_in_inv  = 1'b0;
      w_out_inv = 1'b0;
      case (i_op)
         OP_AND:  ;
         OP_NAND: w_out_inv = 1'b1;
         OP_OR:   begin w_in_inv = 1'b1; w_out_inv = 1'b1; end
         OP_NOR:  w_in_inv = 1'b1;
         default: ;
      endcase
   end

   not16_gate u_inv_a (.i_a(i_a), .o_y(w_a_n));
   not16_gate u_inv_b (.i_a(i_b), .o_y(w_b_n));

   assign w_core_a = w_in_inv ? w_a_n : i_a;
   assign w_core_b = w_in_inv ? w_b_n : i_b;

   and16_gate u_and (.i_a(w_core_a), .i_b(w_core_b), .o_y(w_core_y));
   not16_gate u_inv_y (.i_a(w_core_y), .o_y(w_core_y_n));

   assign o_out = w_out_inv ? w_core_y_n : w_core_y;
endmodule

// File: rtl/not16_gate.sv
// 16-bit bitwise inverter used for operand and result inversion.
module not16_gate (
   input  logic [15:0] i_a,
   output logic [15:0] o_y
);
   assign o_y = ~i_a;
endmodule

// File: rtl/bitwise_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise datapath between two requesters;
// one operation in flight: IDLE (accept) -> EXEC (compute) -> RESP (hold).
module bitwise_unit_arbiter
   import bitwise_ops_defs::*;
#(
   parameter logic RR_INIT = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [15:0] req0_a,
   input  logic [15:0] req0_b,
   input  logic [1:0]  req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [15:0] req1_a,
   input  logic [15:0] req1_b,
   input  logic [1:0]  req1_op,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [15:0] resp_data,
   output logic        resp_id,
   output logic        busy
);
   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_prio;
   logic [15:0] r_a;
   logic [15:0] r_b;
   logic [1:0]  r_op;
   logic        r_id;
   logic [15:0] r_resp_data;
   logic        r_resp_id;
   logic        w_grant0;
   logic        w_grant1;
   logic        w_accept;
   logic [15:0] w_result;

   always_comb begin
      w_grant0    = req0_valid && (!req1_valid || (r_prio == 1'b0));
      w_grant1    = req1_valid && (!req0_valid || (r_prio == 1'b1));
      // Readies stay low while reset is held even though the state is IDLE.
      req0_ready  = (r_state == S_IDLE) && w_grant0 && !reset;
      req1_ready  = (r_state == S_IDLE) && w_grant1 && !reset;
      w_accept    = req0_ready || req1_ready;
      resp_valid  = (r_state == S_RESP);
      busy        = (r_state != S_IDLE);
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)   w_state_nxt = S_EXEC;
         S_EXEC:                  w_state_nxt = S_RESP;
         S_RESP:  if (resp_ready) w_state_nxt = S_IDLE;
         default:                 w_state_nxt = S_IDLE;
      endcase
   end

   bitwise_op_unit u_op_unit (
      .i_op  (r_op),
      .i_a   (r_a),
      .i_b   (r_b),
      .o_out (w_result)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_prio      <= RR_INIT;
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= '0;
         r_id        <= 1'b0;
         r_resp_data <= '0;
         r_resp_id   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_a    <= w_grant1 ? req1_a  : req0_a;
            r_b    <= w_grant1 ? req1_b  : req0_b;
            r_op   <= w_grant1 ? req1_op : req0_op;
            r_id   <= w_grant1;
            r_prio <= ~w_grant1;
         end
         if (r_state == S_EXEC) begin
            r_resp_data <= w_result;
            r_resp_id   <= r_id;
         end
      end
   end

   assign resp_data = r_resp_data;
   assign resp_id   = r_resp_id;
endmodule

// File: tb/tb_bitwise_unit_arbiter.sv
// Directed scoreboard bench for bitwise_unit_arbiter: expected results are
// queued at each request handshake and compared at each response handshake.
module tb_bitwise_unit_arbiter;
   typedef struct packed {
      logic [15:0] data;
      logic        id;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [1:0]  req0_op = '0, req1_op = '0;
   logic        resp_valid, resp_id, busy;
   logic        resp_ready = 1'b0;
   logic [15:0] resp_data;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   bitwise_unit_arbiter #(.RR_INIT(1'b0)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_id(resp_id), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         2'b00:   return a & b;
         2'b01:   return ~(a & b);
         2'b10:   return a | b;
         default: return ~(a | b);
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Records handshakes visible just before the coming edge, then advances one cycle.
   task automatic tick();
      exp_t e;
      #1;
      if (req0_valid && req0_ready) sb.push_back('{data: model(req0_op, req0_a, req0_b), id: 1'b0});
      if (req1_valid && req1_ready) sb.push_back('{data: model(req1_op, req1_a, req1_b), id: 1'b1});
      if (resp_valid && resp_ready) begin
         if (sb.size() == 0) check("resp_unexpected", 32'(sb.size()), 32'd1);
         else begin
            e = sb.pop_front();
            check("sb_data", 32'(resp_data), 32'(e.data));
            check("sb_id", 32'(resp_id), 32'(e.id));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic issue_solo(input logic id, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
      if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
      else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
      #1;
      check(id ? "solo_ready1" : "solo_ready0", 32'(id ? req1_ready : req0_ready), 32'd1);
      check("solo_other_ready", 32'(id ? req0_ready : req1_ready), 32'd0);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic drain();
      resp_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (!busy && sb.size() == 0) break;
         tick();
      end
      check("drain_busy", 32'(busy), 32'd0);
      check("drain_sb_empty", 32'(sb.size()), 32'd0);
      resp_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] op_exp [3];
      logic [15:0] held_data;
      int          grants;

      // Reset state, with a request pending to show readies are gated.
      req0_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready0", 32'(req0_ready), 32'd0);
      check("rst_ready1", 32'(req1_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_data", 32'(resp_data), 32'h0000);
      check("rst_resp_id", 32'(resp_id), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      req0_valid = 1'b0;
      reset = 1'b0;
      tick();

      // Single request and exact latency.
      issue_solo(1'b0, 16'hF0F0, 16'hFF00, 2'b00);
      check("lat_exec_busy", 32'(busy), 32'd1);
      check("lat_exec_valid", 32'(resp_valid), 32'd0);
      tick();
      check("lat_resp_valid", 32'(resp_valid), 32'd1);
      check("single_data", 32'(resp_data), 32'h0000F000);
      check("single_id", 32'(resp_id), 32'd0);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("single_back_idle", 32'(busy), 32'd0);
      check("single_valid_drop", 32'(resp_valid), 32'd0);

      // Op coverage on requester 1.
      op_exp[0] = 16'hFFCB;
      op_exp[1] = 16'h12FF;
      op_exp[2] = 16'hED00;
      for (int k = 0; k < 3; k++) begin
         issue_solo(1'b1, 16'h1234, 16'h00FF, 2'(k + 1));
         tick();
         check("op_data", 32'(resp_data), 32'(op_exp[k]));
         check("op_id", 32'(resp_id), 32'd1);
         drain();
      end

      // Contention: both valid continuously, grants must alternate 0,1,0,1.
      grants = 0;
      resp_ready = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int c = 0; c < 20 && grants < 4; c++) begin
         req0_a = 16'h1111 * 16'(c); req0_b = 16'hA5A5; req0_op = 2'(c);
         req1_a = 16'h0F0F ^ 16'(c); req1_b = 16'h3C3C; req1_op = 2'(c + 1);
         #1;
         check("cont_not_both", 32'(req0_ready && req1_ready), 32'd0);
         if (busy) check("cont_busy_no_ready", 32'(req0_ready || req1_ready), 32'd0);
         else begin
            check("cont_grant_order", 32'(req1_ready), 32'(grants % 2));
            check("cont_granted", 32'(req0_ready || req1_ready), 32'd1);
            grants++;
         end
         tick();
      end
      check("cont_grant_count", 32'(grants), 32'd4);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      drain();

      // Backpressure: response held 5 cycles, waiting requester never ready.
      issue_solo(1'b0, 16'hAAAA, 16'h5555, 2'b10);
      tick();
      held_data = resp_data;
      check("bp_data0", 32'(held_data), 32'h0000FFFF);
      req1_valid = 1'b1; req1_a = 16'hC3C3; req1_b = 16'hFFFF; req1_op = 2'b01;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_valid", 32'(resp_valid), 32'd1);
         check("bp_data", 32'(resp_data), 32'(held_data));
         check("bp_id", 32'(resp_id), 32'd0);
         check("bp_req1_wait", 32'(req1_ready), 32'd0);
         tick();
      end
      resp_ready = 1'b1;
      #1;
      check("bp_req1_no_bypass", 32'(req1_ready), 32'd0);
      tick();
      resp_ready = 1'b0;
      #1;
      check("bp_req1_after_hs", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      drain();

      // Reset mid-EXEC after moving prio away from RR_INIT.
      issue_solo(1'b0, 16'h00FF, 16'h0F0F, 2'b00);
      check("mid_exec_busy", 32'(busy), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_valid", 32'(resp_valid), 32'd0);
      sb.delete();
      #1;
      reset = 1'b0;
      req0_valid = 1'b1; req0_a = 16'h8001; req0_b = 16'hFFFF; req0_op = 2'b11;
      req1_valid = 1'b1; req1_a = 16'h7777; req1_b = 16'h1111; req1_op = 2'b00;
      #1;
      check("post_rst_prio_r0", 32'(req0_ready), 32'd1);
      check("post_rst_prio_r1", 32'(req1_ready), 32'd0);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      drain();

      // Pointer holds across idle cycles.
      issue_solo(1'b0, 16'h1357, 16'h2468, 2'b01);
      drain();
      repeat (10) tick();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      check("idle_hold_r1", 32'(req1_ready), 32'd1);
      check("idle_hold_r0", 32'(req0_ready), 32'd0);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/bitwise_unit_arbiter.md
Name: bitwise_unit_arbiter

Overview:
- Shares one 16-bit bitwise datapath (and16_gate core plus output inversion) between two requesters, e.g. ALU-test sequencer and CPU-side helper.
- Handles round-robin arbitration, operand capture, one execute cycle, and a held response with a valid/ready handshake.
- Sits between requester logic and the gate-level datapath. Only one operation is in flight at a time.

Parameters:
- RR_INIT, 0, requester holding priority after reset (0 or 1).

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high; clears all state.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 accepted this cycle.
- req0_a  input  16  operand A, requester 0.
- req0_b  input  16  operand B, requester 0.
- req0_op  input  2  operation, requester 0.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer takes result.
- resp_data  output  16  result word.
- resp_id  output  1  requester that issued the result.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Op encoding: 00 AND = a&b; 01 NAND = ~(a&b); 10 OR = ~(~a & ~b); 11 NOR = ~a & ~b.
- All four ops use the single shared and16 instance: optional input inversion, then optional output inversion.
- FSM states: IDLE, EXEC, RESP. Reset → IDLE.
- IDLE:
  - Grant is combinational from req*_valid and priority pointer prio.
  - Only one valid → that requester is granted.
  - Both valid → requester prio is granted.
  - reqN_ready = (state==IDLE) && grantN. At most one ready is high.
  - On handshake (valid && ready) at edge T:
    - capture a, b, op, id into registers;
    - set prio = ~granted id;
    - state → EXEC.
  - No valid → stay IDLE; prio unchanged.
- EXEC (one cycle): registered operands drive the datapath. At the next edge, resp_data and resp_id are registered; state → RESP.
- RESP:
  - resp_valid = 1. resp_data and resp_id stay stable until the handshake.
  - resp_valid && resp_ready at an edge → IDLE.
  - No bypass: a new request is accepted no earlier than the cycle after the response handshake. Minimum issue interval is 3 cycles.
- Latency: accept at edge T → resp_valid high from T+2, i.e. visible in the cycle after the second edge.
- Requests presented while not in IDLE see ready = 0 and must hold. Changing a waiting requester's operands is allowed; values are sampled only at the handshake edge.
- Reset values: req0_ready = req1_ready = 0 (state IDLE, but outputs are gated until reset deasserts); resp_valid = 0; resp_data = 16'h0000; resp_id = 0; busy = 0; prio = RR_INIT; operand registers = 0.
- Reset asserted mid-transaction (EXEC or RESP): immediate return to IDLE. The in-flight result is discarded and resp_valid drops asynchronously.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- resp_ready held high in RESP gives a 1-cycle RESP. resp_ready outside RESP is ignored.
- X/undefined op is not possible: all 2-bit codes are defined.

Decomposition:
- Shared package/header (bitwise_ops_defs):
  - OP_AND/OP_NAND/OP_OR/OP_NOR 2-bit constants;
  - FSM state encodings S_IDLE=2'd0, S_EXEC=2'd1, S_RESP=2'd2.
- Sub-module bitwise_op_unit (combinational): op, a, b → out. It instantiates and16_gate plus input/output inversion (not16_gate) selected by op.
- Arbiter, FSM and registers stay in bitwise_unit_arbiter.

Test Plan:
- Reset then single request: req0 a=16'hF0F0, b=16'hFF00, op=AND → req0_ready at T; resp_valid at T+2 with resp_data=16'hF000, resp_id=0; resp_ready=1 → IDLE next cycle.
- Op coverage on requester 1: a=16'h1234, b=16'h00FF.
  - NAND → 16'hFFCB.
  - OR → 16'h12FF.
  - NOR → 16'hED00.
  - All with resp_id=1.
- Contention, both valid every cycle, RR_INIT=0: grant order 0,1,0,1. Each response id matches, and the requester not granted never sees ready.
- Backpressure: resp_ready=0 for 5 cycles in RESP → resp_valid, data and id stable. req1_valid high meanwhile with req1_ready=0 throughout; accepted only in the cycle after the response handshake.
- Reset mid-EXEC: assert reset asynchronously between edges → busy=0 and resp_valid=0 immediately, prio=RR_INIT. After release, the next request completes normally.
- Idle pointer hold: grant 0, then idle 10 cycles, then both valid → requester 1 is granted.
